mem_addr_arbiter: RTL and testbench
===================================

// Module: mem_addr_arbiter
// PURPOSE
//   Shares the single 10-bit memory address path between four address requesters
//   (PC fetch, ALU/effective address, stack, I/O). The requesters are data0..data3
//   of addr_mux4.
//   Round-robin arbitration; drives the addr_mux4 select and sequences one memory
//   access at a time with a ready/timeout handshake.
//   Sits between the multicycle control unit and the memory interface.
// PARAMETERS
//   ADDR_W    10  width of every address input and of mem_addr
//   TIMEOUT   8   max ACCESS cycles waiting for mem_ready before forced release
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   req        in   4       per-requester access request, held until ack
//   addr0      in   ADDR_W  requester 0 address
//   addr1      in   ADDR_W  requester 1 address
//   addr2      in   ADDR_W  requester 2 address
//   addr3      in   ADDR_W  requester 3 address
//   mem_ready  in   1       memory signals access complete (sampled in ACCESS only)
//   grant      out  4       one-hot owner of the address path; 0 when idle
//   mux_sel    out  2       registered select to addr_mux4 (binary index of grant)
//   mem_addr   out  ADDR_W  addr_mux4 output = addr[mux_sel]
//   mem_en     out  1       high for every ACCESS cycle
//   ack        out  4       one-cycle pulse to the owner on completion or timeout
//   err        out  1       one-cycle pulse coincident with ack on timeout
// BEHAVIOUR
//   - Reset (async, immediate)
//     - state=IDLE; grant, mux_sel, mem_en, ack, err = 0.
//     - rr_ptr=3, so requester 0 has first priority; timeout count=0.
//   - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   - IDLE
//     - If req!=0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... (mod 4).
//     - Register grant/mux_sel, set mem_en, clear count, go to ACCESS.
//     - If req==0, hold all outputs 0.
//   - ACCESS
//     - grant, mux_sel and mem_en are held stable; count increments each cycle.
//     - mem_ready=1 -> go to DONE, no error.
//     - count==TIMEOUT-1 with mem_ready=0 -> go to DONE and flag error.
//   - DONE (exactly one cycle)
//     - ack[owner]=1; err=flag; mem_en=0; grant=0.
//     - rr_ptr<=owner; go to IDLE.
//     - mux_sel keeps its last value.
//   - Latency
//     - req sampled at edge n -> grant/mem_en visible after edge n.
//     - mem_ready sampled at edge k -> ack visible after edge k.
//     - Minimum 3 cycles per access (IDLE, ACCESS, DONE); no back-to-back grant
//       without an IDLE cycle.
//   - Boundary cases
//     - req deasserted mid-ACCESS: the access still completes and ack is still
//       pulsed.
//     - req changing in ACCESS/DONE is ignored until IDLE.
//     - mem_ready outside ACCESS is ignored.
//     - rr_ptr wraps 3->0; the search is a 2-bit modular add.
//     - Timeout count width = $clog2(TIMEOUT+1).
//     - Reset mid-ACCESS aborts the access with no ack and no err.
//   - mem_addr is combinational from mux_sel through addr_mux4; it changes only
//     when mux_sel changes or the selected address input changes.
// STRUCTURE
//   - Shared package/include: state localparams S_IDLE=2'd0, S_ACCESS=2'd1,
//     S_DONE=2'd2; NUM_REQ=4.
//   - Sub-module: the existing addr_mux4 is instantiated for mem_addr, with select
//     tied to mux_sel.
//   - Arbiter FSM, rr_ptr and timeout counter live in this module.
// TESTING
//   1. Reset, then req=4'b0100, addr2=10'd512, mem_ready high on the 2nd ACCESS
//      cycle -> grant=0100, mux_sel=2, mem_addr=512, mem_en for 2 cycles,
//      ack=0100 for 1 cycle, err=0.
//   2. req=4'b1111 held, mem_ready=1 -> grants in order 0,1,2,3,0; each ack
//      3 cycles apart.
//   3. req=4'b1001 after reset -> grant 0 first; then with req=4'b1001 still held
//      -> grant 3, then 0.
//   4. req=4'b0010, mem_ready=0 forever, TIMEOUT=8 -> mem_en for 8 cycles, then
//      ack=0010 and err=1 together for 1 cycle, then grant=0.
//   5. reset pulsed mid-ACCESS -> all outputs 0 without waiting for clk; no ack;
//      next req=4'b1000 -> grant=1000.
//   6. req[1] dropped on the 1st ACCESS cycle, mem_ready on the 3rd -> access
//      completes and ack=0010 still pulses once.

Source files
------------

// File: rtl/mem_addr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_addr_arbiter_pkg
//   Shared definitions for the memory address arbiter: FSM state encodings,
//   requester count, and the round-robin pick / one-hot helpers used by the
//   arbiter FSM.
// ---------------------------------------------------------------------------
package mem_addr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_DONE   = 2'd2;

  // Result of a round-robin search: whether any requester won, and which one.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Search ptr+1, ptr+2, ... (mod 4) and return the first requester with req set.
  // The 2-bit add wraps naturally, so ptr=3 starts the search at requester 0.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [1:0]         ptr);
    pick_t      res;
    logic [1:0] cand;
    res.valid = 1'b0;
    res.idx   = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + 2'(i);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  // Binary requester index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_addr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_addr_arbiter_if
//   Bundles the requester side (req, addr0..addr3), the memory handshake
//   (mem_ready, mem_en, mem_addr) and the arbitration results (grant, mux_sel,
//   ack, err) of the memory address arbiter.
//   modport master : requesters / memory model side (drives req, addrs, mem_ready)
//   modport slave  : the arbiter itself (drives grant, mux_sel, mem_addr,
//                    mem_en, ack, err)
// ---------------------------------------------------------------------------
interface mem_addr_arbiter_if
  import mem_addr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic [NUM_REQ-1:0] req;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [ADDR_W-1:0]  addr2;
  logic [ADDR_W-1:0]  addr3;
  logic               mem_ready;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         mux_sel;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_en;
  logic [NUM_REQ-1:0] ack;
  logic               err;

  modport master (
    output req, addr0, addr1, addr2, addr3, mem_ready,
    input  grant, mux_sel, mem_addr, mem_en, ack, err
  );

  modport slave (
    input  req, addr0, addr1, addr2, addr3, mem_ready,
    output grant, mux_sel, mem_addr, mem_en, ack, err
  );

endinterface

// File: rtl/mem_addr_arbiter_mux4.sv
// ---------------------------------------------------------------------------
// addr_mux4
//   Four-way address multiplexer feeding the memory address path.
//   data0..data3 : W-bit address inputs
//   sel          : 2-bit binary select
//   y            : data[sel], purely combinational
// ---------------------------------------------------------------------------
module addr_mux4 #(
  parameter int W = 10
) (
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  input  logic [W-1:0] data3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  // Select one of the four address inputs.
  always_comb begin
    y = data0;
    case (sel)
      2'd0:    y = data0;
      2'd1:    y = data1;
      2'd2:    y = data2;
      2'd3:    y = data3;
      default: y = data0;
    endcase
  end

endmodule

// File: rtl/mem_addr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_addr_arbiter
//   Shares one memory address path between four requesters (PC fetch, ALU /
//   effective address, stack, I/O) with round-robin arbitration, and runs one
//   memory access at a time through a ready/timeout handshake.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : mem_addr_arbiter_if.slave
//               req[3:0], addr0..addr3, mem_ready  (inputs)
//               grant[3:0] one-hot owner, 0 when idle
//               mux_sel    registered binary select of the owner
//               mem_addr   addr[mux_sel] through addr_mux4
//               mem_en     high in every ACCESS cycle
//               ack[3:0]   one-cycle pulse to the owner at completion/timeout
//               err        one-cycle pulse with ack when the access timed out
//   Sequence: IDLE -> ACCESS -> DONE -> IDLE, so at least three cycles per
//   access and never two grants back to back without an IDLE cycle.
// ---------------------------------------------------------------------------
module mem_addr_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_addr_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Registered state and outputs.
  state_t             state_r;
  logic [1:0]         rr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [1:0]         mux_sel_r;
  logic               mem_en_r;
  logic [NUM_REQ-1:0] ack_r;
  logic               err_r;

  // Next-cycle values.
  state_t             state_s;
  logic [1:0]         rr_ptr_s;
  logic [CNT_W-1:0]   count_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [1:0]         mux_sel_s;
  logic               mem_en_s;
  logic [NUM_REQ-1:0] ack_s;
  logic               err_s;

  pick_t              pick_s;
  logic               timeout_s;
  logic               finish_s;

  assign pick_s    = rr_pick(bus.req, rr_ptr_r);
  assign timeout_s = (count_r == CNT_W'(TIMEOUT - 1));
  // Ready wins over timeout when both happen in the same cycle.
  assign finish_s  = bus.mem_ready || timeout_s;

  // State and output registers; reset aborts any access with no ack/err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      rr_ptr_r  <= 2'd3;
      count_r   <= {CNT_W{1'b0}};
      grant_r   <= {NUM_REQ{1'b0}};
      mux_sel_r <= 2'd0;
      mem_en_r  <= 1'b0;
      ack_r     <= {NUM_REQ{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      count_r   <= count_s;
      grant_r   <= grant_s;
      mux_sel_r <= mux_sel_s;
      mem_en_r  <= mem_en_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
    end
  end

  // Next-state decode for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_s.valid) begin
          state_s = S_ACCESS;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (finish_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ACCESS;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and timeout counter.
  always_comb begin
    rr_ptr_s  = rr_ptr_r;
    count_s   = count_r;
    grant_s   = grant_r;
    mux_sel_s = mux_sel_r;
    mem_en_s  = mem_en_r;
    ack_s     = {NUM_REQ{1'b0}};
    err_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pick_s.valid) begin
          grant_s   = idx_to_onehot(pick_s.idx);
          mux_sel_s = pick_s.idx;
          mem_en_s  = 1'b1;
          count_s   = {CNT_W{1'b0}};
        end else begin
          // mux_sel keeps pointing at the last owner while idle.
          grant_s  = {NUM_REQ{1'b0}};
          mem_en_s = 1'b0;
        end
      end
      S_ACCESS: begin
        if (finish_s) begin
          // ack/err become visible in the DONE cycle.
          grant_s  = {NUM_REQ{1'b0}};
          mem_en_s = 1'b0;
          ack_s    = grant_r;
          err_s    = !bus.mem_ready;
        end else begin
          count_s = count_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        rr_ptr_s = mux_sel_r;
        grant_s  = {NUM_REQ{1'b0}};
        mem_en_s = 1'b0;
      end
      default: begin
        grant_s  = {NUM_REQ{1'b0}};
        mem_en_s = 1'b0;
        count_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.grant   = grant_r;
  assign bus.mux_sel = mux_sel_r;
  assign bus.mem_en  = mem_en_r;
  assign bus.ack     = ack_r;
  assign bus.err     = err_r;

  addr_mux4 #(
    .W (ADDR_W)
  ) u_addr_mux4 (
    .data0 (bus.addr0),
    .data1 (bus.addr1),
    .data2 (bus.addr2),
    .data3 (bus.addr3),
    .sel   (mux_sel_r),
    .y     (bus.mem_addr)
  );

endmodule

// File: tb/tb_mem_addr_arbiter.sv
module tb_mem_addr_arbiter;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mem_addr_arbiter_if #(.ADDR_W(10)) bus ();

  mem_addr_arbiter #(
    .ADDR_W  (10),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.addr0 = 10'd7;
    bus.addr1 = 10'd100;
    bus.addr2 = 10'd200;
    bus.addr3 = 10'd900;
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    tests_run++;
    if (bus.mux_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_mux_sel: got %0d want 0", bus.mux_sel); end
    tests_run++;
    if (bus.mem_en !== 1'b0 || bus.ack !== 4'b0000 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outputs: mem_en=%b ack=%b err=%b want 0/0000/0", bus.mem_en, bus.ack, bus.err);
    end
    tests_run++;
    if (bus.mem_addr !== 10'd7) begin tests_failed++; $display("FAIL reset_mem_addr: got %0d want 7", bus.mem_addr); end
    bus.req = 4'b0000;
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.addr2 = 10'd512;
    bus.req = 4'b0100;
    tick();  // ACCESS cycle 1
    tests_run++;
    if (bus.grant !== 4'b0100 || bus.mux_sel !== 2'd2) begin
      tests_failed++; $display("FAIL single_grant: grant=%b sel=%0d want 0100/2", bus.grant, bus.mux_sel);
    end
    tests_run++;
    if (bus.mem_addr !== 10'd512 || bus.mem_en !== 1'b1 || bus.ack !== 4'b0000) begin
      tests_failed++; $display("FAIL single_acc1: addr=%0d en=%b ack=%b want 512/1/0000", bus.mem_addr, bus.mem_en, bus.ack);
    end
    tick();  // ACCESS cycle 2
    tests_run++;
    if (bus.mem_en !== 1'b1 || bus.grant !== 4'b0100) begin
      tests_failed++; $display("FAIL single_acc2: en=%b grant=%b want 1/0100", bus.mem_en, bus.grant);
    end
    bus.addr2 = 10'd300;
    #1;
    tests_run++;
    if (bus.mem_addr !== 10'd300) begin tests_failed++; $display("FAIL single_addr_follow: got %0d want 300", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    tick();  // DONE
    bus.mem_ready = 1'b0;
    bus.req = 4'b0000;
    tests_run++;
    if (bus.ack !== 4'b0100 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL single_done: ack=%b err=%b want 0100/0", bus.ack, bus.err);
    end
    tests_run++;
    if (bus.mem_en !== 1'b0 || bus.grant !== 4'b0000 || bus.mux_sel !== 2'd2) begin
      tests_failed++; $display("FAIL single_done_outs: en=%b grant=%b sel=%0d want 0/0000/2", bus.mem_en, bus.grant, bus.mux_sel);
    end
    tick();  // IDLE
    tests_run++;
    if (bus.ack !== 4'b0000 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL single_idle: ack=%b grant=%b want 0000/0000", bus.ack, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    apply_reset();
    bus.req = 4'b1111;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();  // ACCESS
      tests_run++;
      if (bus.grant !== exp_g[k] || bus.mem_en !== 1'b1 || bus.ack !== 4'b0000) begin
        tests_failed++; $display("FAIL rr_grant%0d: grant=%b en=%b ack=%b want %b/1/0000", k, bus.grant, bus.mem_en, bus.ack, exp_g[k]);
      end
      tick();  // DONE
      tests_run++;
      if (bus.ack !== exp_g[k] || bus.err !== 1'b0 || bus.grant !== 4'b0000) begin
        tests_failed++; $display("FAIL rr_ack%0d: ack=%b err=%b grant=%b want %b/0/0000", k, bus.ack, bus.err, bus.grant, exp_g[k]);
      end
      if (k == 4) bus.req = 4'b0000;
      tick();  // IDLE
      tests_run++;
      if (bus.grant !== 4'b0000 || bus.ack !== 4'b0000 || bus.mem_en !== 1'b0) begin
        tests_failed++; $display("FAIL rr_idle%0d: grant=%b ack=%b en=%b want 0000/0000/0", k, bus.grant, bus.ack, bus.mem_en);
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001;
    apply_reset();
    bus.req = 4'b1001;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();  // ACCESS
      tests_run++;
      if (bus.grant !== exp_g[k]) begin
        tests_failed++; $display("FAIL prio_grant%0d: grant=%b want %b", k, bus.grant, exp_g[k]);
      end
      tick();  // DONE
      tests_run++;
      if (bus.ack !== exp_g[k]) begin
        tests_failed++; $display("FAIL prio_ack%0d: ack=%b want %b", k, bus.ack, exp_g[k]);
      end
      if (k == 2) bus.req = 4'b0000;
      tick();  // IDLE
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bus.req = 4'b0010;
    bus.mem_ready = 1'b0;
    tick();  // ACCESS, count 0
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bus.mem_en !== 1'b1 || bus.grant !== 4'b0010 || bus.ack !== 4'b0000 || bus.err !== 1'b0) begin
        tests_failed++; $display("FAIL to_access%0d: en=%b grant=%b ack=%b err=%b want 1/0010/0000/0", i, bus.mem_en, bus.grant, bus.ack, bus.err);
      end
      tick();
    end
    bus.req = 4'b0000;
    tests_run++;
    if (bus.ack !== 4'b0010 || bus.err !== 1'b1 || bus.mem_en !== 1'b0 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL to_done: ack=%b err=%b en=%b grant=%b want 0010/1/0/0000", bus.ack, bus.err, bus.mem_en, bus.grant);
    end
    tick();
    tests_run++;
    if (bus.ack !== 4'b0000 || bus.err !== 1'b0 || bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL to_idle: ack=%b err=%b grant=%b want 0000/0/0000", bus.ack, bus.err, bus.grant);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.req = 4'b0100;
    tick();  // ACCESS
    tests_run++;
    if (bus.mem_en !== 1'b1 || bus.grant !== 4'b0100) begin
      tests_failed++; $display("FAIL rmid_access: en=%b grant=%b want 1/0100", bus.mem_en, bus.grant);
    end
    #2;
    reset = 1'b1;
    #1;  // no clock edge in between
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.mem_en !== 1'b0 || bus.mux_sel !== 2'd0 || bus.ack !== 4'b0000 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_async: grant=%b en=%b sel=%0d ack=%b err=%b want all 0", bus.grant, bus.mem_en, bus.mux_sel, bus.ack, bus.err);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tests_run++;
    if (bus.ack !== 4'b0000 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_noack: ack=%b err=%b want 0000/0", bus.ack, bus.err);
    end
    reset = 1'b0;
    tick();
    bus.req = 4'b1000;
    tick();
    tests_run++;
    if (bus.grant !== 4'b1000 || bus.mux_sel !== 2'd3) begin
      tests_failed++; $display("FAIL rmid_regrant: grant=%b sel=%0d want 1000/3", bus.grant, bus.mux_sel);
    end
    bus.mem_ready = 1'b1;
    tick();  // DONE
    bus.mem_ready = 1'b0;
    bus.req = 4'b0000;
    tests_run++;
    if (bus.ack !== 4'b1000) begin tests_failed++; $display("FAIL rmid_ack: ack=%b want 1000", bus.ack); end
    tick();
  endtask

  task automatic test_req_drop();
    int ack_pulses;
    ack_pulses = 0;
    bus.req = 4'b0010;
    tick();  // ACCESS 1
    bus.req = 4'b0000;
    tests_run++;
    if (bus.grant !== 4'b0010) begin tests_failed++; $display("FAIL drop_grant: grant=%b want 0010", bus.grant); end
    tick();  // ACCESS 2
    tests_run++;
    if (bus.mem_en !== 1'b1 || bus.grant !== 4'b0010) begin
      tests_failed++; $display("FAIL drop_acc2: en=%b grant=%b want 1/0010", bus.mem_en, bus.grant);
    end
    tick();  // ACCESS 3
    bus.mem_ready = 1'b1;
    tests_run++;
    if (bus.mem_en !== 1'b1) begin tests_failed++; $display("FAIL drop_acc3: en=%b want 1", bus.mem_en); end
    tick();  // DONE
    bus.mem_ready = 1'b0;
    tests_run++;
    if (bus.ack !== 4'b0010 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL drop_ack: ack=%b err=%b want 0010/0", bus.ack, bus.err);
    end
    // mem_ready while idle must do nothing.
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ack !== 4'b0000) ack_pulses++;
    end
    bus.mem_ready = 1'b0;
    tests_run++;
    if (ack_pulses != 0 || bus.grant !== 4'b0000 || bus.mem_en !== 1'b0) begin
      tests_failed++; $display("FAIL drop_idle: extra_acks=%0d grant=%b en=%b want 0/0000/0", ack_pulses, bus.grant, bus.mem_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.mem_ready = 1'b0;
    bus.addr0 = 10'd0;
    bus.addr1 = 10'd0;
    bus.addr2 = 10'd0;
    bus.addr3 = 10'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_reset_mid_access();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
